ray_dispatcher: RTL and testbench
=================================

# ray_dispatcher

Hands pixel coordinates from the `ray_signal_gen` pixel counter to a pool of ray-tracing cores. Drives the counter's `new_ray` advance strobe and reads the counter's held `pixel_h`/`pixel_v`. Issues each pixel exactly once, in counter order, to a ready core chosen round-robin. Signals frame completion after pixel (WIDTH-1, HEIGHT-1) has been issued.

## Interface
- `WIDTH`, default 1280: frame width; must match the pixel counter.
- `HEIGHT`, default 720: frame height; must match the pixel counter.
- `NUM_CORES`, default 4: number of tracer cores, ≥2.
- `clk`, input, 1: system clock.
- `rst`, input, 1: synchronous, active-high reset. Shared with the pixel counter.
- `start`, input, 1: begin a frame. Sampled only in IDLE.
- `pixel_h`, input, 11: current column from the counter.
- `pixel_v`, input, 10: current row from the counter.
- `new_ray`, output, 1: registered advance strobe to the counter.
- `core_ready`, input, NUM_CORES: per-core ready.
- `ray_valid`, output, NUM_CORES: registered one-hot issue strobe.
- `ray_pixel_h`, output, 11: issued column. Shared bus, meaningful while `ray_valid` ≠ 0.
- `ray_pixel_v`, output, 10: issued row. Shared bus, meaningful while `ray_valid` ≠ 0.
- `busy`, output, 1: high in every state except IDLE.
- `frame_done`, output, 1: one-cycle pulse on frame completion.

## Operation
- **States:**
  - IDLE → STEP when `start`=1; `new_ray`<=1 on that transition.
  - STEP → ARB unconditionally; lasts exactly 1 cycle while the counter updates.
  - ARB: stays in ARB while no core is ready; outputs hold 0.
  - ARB with ≥1 ready core:
    - select a core; `ray_valid`<=onehot(sel); `ray_pixel_*`<=`pixel_*`; `rr_ptr`<=(sel+1) mod NUM_CORES.
    - if not the last pixel: `new_ray`<=1, → STEP.
    - if the last pixel (`pixel_h`==WIDTH-1 and `pixel_v`==HEIGHT-1): → DONE.
  - DONE → IDLE; `frame_done`<=1.
- **Arbitration:**
  - Pick the first core with `core_ready` set, scanning from `rr_ptr` upward and wrapping.
  - `rr_ptr` is $clog2(NUM_CORES) bits, reset 0.
- **Handshake:**
  - Transfer occurs in the cycle `ray_valid[i]`=1.
  - A core that raises `core_ready` holds it until it receives `ray_valid`.
  - `core_ready` is sampled only in ARB.
- **Pixel order:**
  - Counter order is `pixel_v` fast, `pixel_h` slow.
  - The counter idles at (WIDTH-1, HEIGHT-1), so the first `new_ray` of a frame yields (0,0).
  - After the last pixel no `new_ray` is issued, leaving the counter at (WIDTH-1, HEIGHT-1) for the next frame.
- **Pulse widths:** `new_ray`, `ray_valid` and `frame_done` are single-cycle pulses, cleared unless set that cycle.
- **Reset values:**
  - state IDLE.
  - all outputs 0, including `ray_pixel_*`.
  - `rr_ptr` 0.
- **Boundary behaviour:**
  - `start` while busy: ignored.
  - `start` in the same cycle as `frame_done`: accepted (state is IDLE).
  - `rst` mid-frame: returns the block to IDLE; a pulse in flight is dropped. The counter is reset by the same `rst`, so the two stay aligned.

## Timing
- **Per-frame latency:**
  - c0: `start` accepted.
  - c1: `new_ray`=1.
  - c2: first ARB.
  - c3: first transfer.
- **Throughput:** with a core always ready, ray k transfers at cycle 3+2k, i.e. one ray per 2 cycles.
- **Frame completion:** `frame_done` is high at cycle 2N+2 for N=WIDTH·HEIGHT.
- **Stalls:** each ARB cycle with no ready core adds one cycle.

## Configuration
- **`RAY_DISPATCH_STATS_EN` defined:** adds two outputs.
  - `frame_cycles` [31:0]: cycles from the `start`-accept cycle to the `frame_done` cycle, latched when `frame_done` rises.
  - `stall_cycles` [31:0]: count of ARB cycles with no ready core; cleared on `start` accept.
  - Both reset to 0.
- **Undefined:** these ports and their counters are absent.

## Structure
- **Shared package `rtx_pkg`:**
  - `dispatch_state_t` enum (IDLE, STEP, ARB, DONE).
  - `PIX_H_BITS`=11.
  - `PIX_V_BITS`=10.
- **Sub-module `rr_pick`:** combinational round-robin chooser.
  - Inputs: `req`[NUM_CORES], `ptr`.
  - Outputs: `any`, `sel` index.
  - Instantiated once.

## Test plan
All scenarios use the pixel counter instantiated with WIDTH=4, HEIGHT=3, NUM_CORES=4.
- **Reset:** assert `rst` → all outputs 0, `busy`=0.
- **All cores ready:**
  - Order: (0,0)→core0, (0,1)→core1, (0,2)→core2, (1,0)→core3, (1,1)→core0, …, (3,2)→core3.
  - Transfers at cycles 3,5,…,25; `frame_done` at cycle 26.
- **Only `core_ready`[2]=1:** all 12 rays go to core 2 at 2-cycle spacing.
- **Stall:** `core_ready`=0 for 10 cycles at the 5th ARB → no `new_ray`, no `ray_valid`; with stats enabled, `stall_cycles`=10 and `frame_cycles`=36.
- **Start handling:**
  - `start` pulsed mid-frame → ignored.
  - `start` after `frame_done` → second frame begins at (0,0) with the `rr_ptr` carried over.
- **Reset mid-frame:** `rst` after the 5th transfer → next cycle all outputs 0; a new `start` re-issues (0,0) to core0.

Source files
------------

// File: rtl/rtx_pkg.sv
// Shared types and widths for the ray dispatch path.
package rtx_pkg;

    localparam int unsigned PIX_H_BITS = 11;
    localparam int unsigned PIX_V_BITS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        ARB  = 2'd2,
        DONE = 2'd3
    } dispatch_state_t;

    typedef struct packed {
        logic [PIX_H_BITS-1:0] h;
        logic [PIX_V_BITS-1:0] v;
    } pixel_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin chooser: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_CORES = 4,
    localparam int unsigned PTR_W = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic                 any,
    output logic [PTR_W-1:0]     sel
);

    always_comb begin
        int unsigned idx;
        any = 1'b0;
        sel = '0;
        idx = 0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!any && req[PTR_W'(idx)]) begin
                any = 1'b1;
                sel = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ray_dispatcher.sv
// Issues pixel-counter coordinates to a pool of tracer cores, one per 2 cycles.
// Optional RAY_DISPATCH_STATS_EN adds frame_cycles / stall_cycles counters.
module ray_dispatcher
    import rtx_pkg::*;
#(
    parameter int unsigned WIDTH     = 1280,
    parameter int unsigned HEIGHT    = 720,
    parameter int unsigned NUM_CORES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PIX_H_BITS-1:0] pixel_h,
    input  logic [PIX_V_BITS-1:0] pixel_v,
    output logic                  new_ray,
    input  logic [NUM_CORES-1:0]  core_ready,
    output logic [NUM_CORES-1:0]  ray_valid,
    output logic [PIX_H_BITS-1:0] ray_pixel_h,
    output logic [PIX_V_BITS-1:0] ray_pixel_v,
    output logic                  busy,
    output logic                  frame_done
`ifdef RAY_DISPATCH_STATS_EN
    ,
    output logic [31:0]           frame_cycles,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int unsigned PTR_W = $clog2(NUM_CORES);

    dispatch_state_t       state, state_n;
    logic                  new_ray_n;
    logic [NUM_CORES-1:0]  ray_valid_n;
    pixel_t                issue_q, issue_n;
    logic [PTR_W-1:0]      rr_ptr, rr_ptr_n;
    logic                  busy_n;
    logic                  frame_done_n;
    logic                  pick_any;
    logic [PTR_W-1:0]      pick_sel;
    logic                  last_pix_c;

    rr_pick #(
        .NUM_CORES(NUM_CORES)
    ) u_pick (
        .req (core_ready),
        .ptr (rr_ptr),
        .any (pick_any),
        .sel (pick_sel)
    );

    assign last_pix_c = (pixel_h == PIX_H_BITS'(WIDTH - 1)) &&
                        (pixel_v == PIX_V_BITS'(HEIGHT - 1));

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_n      = state;
        new_ray_n    = 1'b0;
        ray_valid_n  = '0;
        issue_n      = issue_q;
        rr_ptr_n     = rr_ptr;
        frame_done_n = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = STEP;
                    new_ray_n = 1'b1;
                end
            end
            STEP: state_n = ARB;
            ARB: begin
                if (pick_any) begin
                    ray_valid_n = NUM_CORES'(1) << pick_sel;
                    issue_n.h   = pixel_h;
                    issue_n.v   = pixel_v;
                    rr_ptr_n    = (pick_sel == PTR_W'(NUM_CORES - 1)) ? '0 : pick_sel + PTR_W'(1);
                    if (last_pix_c) begin
                        state_n = DONE;
                    end else begin
                        state_n   = STEP;
                        new_ray_n = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n      = IDLE;
                frame_done_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            new_ray    <= 1'b0;
            ray_valid  <= '0;
            issue_q    <= '0;
            rr_ptr     <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            new_ray    <= new_ray_n;
            ray_valid  <= ray_valid_n;
            issue_q    <= issue_n;
            rr_ptr     <= rr_ptr_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
        end
    end

    assign ray_pixel_h = issue_q.h;
    assign ray_pixel_v = issue_q.v;

`ifdef RAY_DISPATCH_STATS_EN
    // cyc_cnt equals the cycle offset from the start-accept cycle.
    logic [31:0] cyc_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt      <= '0;
            frame_cycles <= '0;
            stall_cycles <= '0;
        end else begin
            if (state == IDLE) begin
                if (start) begin
                    cyc_cnt      <= 32'd1;
                    stall_cycles <= '0;
                end
            end else begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (state == ARB && !pick_any) stall_cycles <= stall_cycles + 32'd1;
            if (state == DONE) frame_cycles <= cyc_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// Self-checking bench for ray_dispatcher with a behavioural pixel counter and schedule model.
`timescale 1ns/1ps
module tb_ray_dispatcher;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int NC = 4;
    localparam int N  = W * H;
    localparam int BUDGET = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] pixel_h;
    logic [9:0]  pixel_v;
    logic        new_ray;
    logic [3:0]  core_ready;
    logic [3:0]  ray_valid;
    logic [10:0] ray_pixel_h;
    logic [9:0]  ray_pixel_v;
    logic        busy;
    logic        frame_done;
`ifdef RAY_DISPATCH_STATS_EN
    logic [31:0] frame_cycles;
    logic [31:0] stall_cycles;
`endif

    ray_dispatcher #(
        .WIDTH(W), .HEIGHT(H), .NUM_CORES(NC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pixel_h     (pixel_h),
        .pixel_v     (pixel_v),
        .new_ray     (new_ray),
        .core_ready  (core_ready),
        .ray_valid   (ray_valid),
        .ray_pixel_h (ray_pixel_h),
        .ray_pixel_v (ray_pixel_v),
        .busy        (busy),
        .frame_done  (frame_done)
`ifdef RAY_DISPATCH_STATS_EN
        ,
        .frame_cycles(frame_cycles),
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Pixel counter: v fast, h slow, idles at the last pixel.
    always @(posedge clk) begin
        if (rst) begin
            pixel_h <= 11'(W - 1);
            pixel_v <= 10'(H - 1);
        end else if (new_ray) begin
            if (pixel_v == 10'(H - 1)) begin
                pixel_v <= '0;
                pixel_h <= (pixel_h == 11'(W - 1)) ? 11'd0 : pixel_h + 11'd1;
            end else begin
                pixel_v <= pixel_v + 10'd1;
            end
        end
    end

    typedef struct {
        int h;
        int v;
        int core;
        int cyc;
    } vec_t;

    vec_t tbl[12];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cur_t = 0;
    int   m_ptr = 0;
    int   last_done_t;
    int   last_stall;
    int   log_t[$];
    int   log_h[$];
    int   log_v[$];
    int   log_core[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): actual %0d, required %0d", name, cur_t, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] rdy, input int p);
        for (int i = 0; i < NC; i++) begin
            if (rdy[(p + i) % NC]) return (p + i) % NC;
        end
        return -1;
    endfunction

    function automatic logic [3:0] next_ready(input int mode, input int t,
                                              input logic [3:0] cur, input logic [3:0] rv);
        logic [3:0] r;
        r = cur;
        case (mode)
            0: r = 4'hF;
            1: r = 4'b0100;
            2: r = (t >= 10 && t <= 19) ? 4'h0 : 4'hF;
            default: begin
                for (int i = 0; i < NC; i++) begin
                    if (r[i] && rv[i]) r[i] = 1'b0;
                    else if (!r[i] && $urandom_range(0, 3) == 0) r[i] = 1'b1;
                end
            end
        endcase
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_new_ray"}, new_ray, 0);
        chk({tag, "_ray_valid"}, ray_valid, 0);
        chk({tag, "_ray_pixel_h"}, ray_pixel_h, 0);
        chk({tag, "_ray_pixel_v"}, ray_pixel_v, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
`ifdef RAY_DISPATCH_STATS_EN
        chk({tag, "_frame_cycles"}, frame_cycles, 0);
        chk({tag, "_stall_cycles"}, stall_cycles, 0);
`endif
    endtask

    // One frame; t=0 is the start-accept cycle. Model: ARB opens 2 cycles after the
    // previous grant (cycle 2 first), each ready-less ARB cycle stalls by one.
    task automatic run_frame(input int mode, input bit mid_start, input bit chain_in,
                             input bit chain_out, input int abort_after);
        int t, k, arb_t, done_t, stall, exp_nr_t, pend_t, pend_core, pend_h, pend_v, seen;
        logic [3:0] rdy;
        log_t.delete(); log_h.delete(); log_v.delete(); log_core.delete();
        if (!chain_in) begin
            @(negedge clk);
            cur_t = -1;
            chk("pre_frame_done", frame_done, 0);
            chk("pre_busy", busy, 0);
            chk("pre_ray_valid", ray_valid, 0);
        end
        start = 1'b1;
        core_ready = next_ready(mode, 0, core_ready, 4'h0);
        k = 0; arb_t = 2; done_t = -1; stall = 0; exp_nr_t = 1;
        pend_t = -1; pend_core = 0; pend_h = 0; pend_v = 0; seen = 0;
        for (t = 1; t <= BUDGET; t++) begin
            @(negedge clk);
            cur_t = t;
            start = (mid_start && (t == 6 || t == 13)) ? 1'b1 : 1'b0;
            chk("ray_valid", ray_valid, (t == pend_t) ? (1 << pend_core) : 0);
            if (t == pend_t) begin
                chk("ray_pixel_h", ray_pixel_h, pend_h);
                chk("ray_pixel_v", ray_pixel_v, pend_v);
            end
            if (ray_valid != 4'h0) begin
                log_t.push_back(t);
                log_h.push_back(int'(ray_pixel_h));
                log_v.push_back(int'(ray_pixel_v));
                log_core.push_back(pick(ray_valid, 0));
                seen++;
            end
            chk("new_ray", new_ray, (t == exp_nr_t) ? 1 : 0);
            chk("busy", busy, (done_t >= 0 && t >= done_t) ? 0 : 1);
            chk("frame_done", frame_done, (t == done_t) ? 1 : 0);
            if (t == done_t) begin
`ifdef RAY_DISPATCH_STATS_EN
                chk("frame_cycles", frame_cycles, done_t);
                chk("stall_cycles", stall_cycles, stall);
`endif
                break;
            end
            if (abort_after > 0 && seen == abort_after) begin
                rst = 1'b1;
                start = 1'b0;
                @(negedge clk);
                cur_t = t + 1;
                check_idle_outputs("abort");
                rst = 1'b0;
                m_ptr = 0;
                return;
            end
            rdy = next_ready(mode, t, core_ready, ray_valid);
            core_ready = rdy;
            if (k < N && t >= arb_t) begin
                if (rdy != 4'h0) begin
                    pend_core = pick(rdy, m_ptr);
                    pend_t = t + 1;
                    pend_h = k / H;
                    pend_v = k % H;
                    m_ptr = (pend_core + 1) % NC;
                    k++;
                    arb_t = t + 2;
                    if (k < N) exp_nr_t = t + 1;
                    else done_t = t + 2;
                end else begin
                    stall++;
                end
            end
        end
        if (t > BUDGET) chk("frame_timeout", 0, 1);
        last_done_t = done_t;
        last_stall = stall;
        if (chain_out) start = 1'b1;
    endtask

    task automatic check_table();
        cur_t = -1;
        chk("table_len", log_t.size(), 12);
        for (int i = 0; i < 12 && i < log_t.size(); i++) begin
            chk($sformatf("tbl_cycle[%0d]", i), log_t[i], tbl[i].cyc);
            chk($sformatf("tbl_h[%0d]", i), log_h[i], tbl[i].h);
            chk($sformatf("tbl_v[%0d]", i), log_v[i], tbl[i].v);
            chk($sformatf("tbl_core[%0d]", i), log_core[i], tbl[i].core);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 0, 0, 3};   tbl[1]  = '{0, 1, 1, 5};
        tbl[2]  = '{0, 2, 2, 7};   tbl[3]  = '{1, 0, 3, 9};
        tbl[4]  = '{1, 1, 0, 11};  tbl[5]  = '{1, 2, 1, 13};
        tbl[6]  = '{2, 0, 2, 15};  tbl[7]  = '{2, 1, 3, 17};
        tbl[8]  = '{2, 2, 0, 19};  tbl[9]  = '{3, 0, 1, 21};
        tbl[10] = '{3, 1, 2, 23};  tbl[11] = '{3, 2, 3, 25};

        rst = 1'b1;
        start = 1'b0;
        core_ready = 4'h0;
        repeat (3) @(negedge clk);
        cur_t = 0;
        check_idle_outputs("reset");
        rst = 1'b0;

        // All cores ready: fixed table of order, cores and transfer cycles.
        run_frame(0, 1'b0, 1'b0, 1'b0, 0);
        check_table();
        chk("all_ready_done_cycle", last_done_t, 26);

        // Only core 2 ready: everything goes to core 2 at 2-cycle spacing.
        run_frame(1, 1'b0, 1'b0, 1'b0, 0);
        chk("core2_done_cycle", last_done_t, 26);
        for (int i = 0; i < log_core.size(); i++) chk("core2_only", log_core[i], 2);

        // Mid-frame start ignored; rr pointer carries over; next start on frame_done cycle.
        run_frame(0, 1'b1, 1'b0, 1'b1, 0);
        cur_t = -1;
        chk("carry_first_core", (log_core.size() > 0) ? log_core[0] : -1, 3);
        chk("carry_done_cycle", last_done_t, 26);

        // Stall of 10 ARB cycles at the 5th ray.
        run_frame(2, 1'b0, 1'b1, 1'b0, 0);
        cur_t = -1;
        chk("stall_done_cycle", last_done_t, 36);
        chk("stall_count", last_stall, 10);
        chk("stall_5th_cycle", (log_t.size() > 4) ? log_t[4] : -1, 21);

        // Reset right after the 5th transfer, then a clean frame from core 0.
        run_frame(0, 1'b0, 1'b0, 1'b0, 5);
        run_frame(0, 1'b0, 1'b0, 1'b0, 0);
        check_table();

        // Randomized readiness against the schedule model.
        for (int f = 0; f < 15; f++) begin
            run_frame(3, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
